// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The slave side is the multiplier; the master side is the operand source and result sink.
interface fp_mul_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   flags;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack, multiply, normalise/round/pack.
// Round-to-nearest-even, subnormals flushed to zero, flags {nv, of, uf, nx}.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  logic adv;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  logic                 s1_sign_q, s1_sign_d;
  logic [1:0]           s1_cls_q, s1_cls_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W:0]       s1_ma_q, s1_ma_d;
  logic [MAN_W:0]       s1_mb_q, s1_mb_d;

  logic                 s2_sign_q, s2_sign_d;
  logic [1:0]           s2_cls_q, s2_cls_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;

  logic [W-1:0] out_q, out_d;
  logic [3:0]   flags_q, flags_d;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_man, b_man;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [1:0]           cls_in;
  logic signed [EW-1:0] exp_in;

  logic                 norm_shift;
  logic [PW-2:0]        prod_n;
  logic [MAN_W-1:0]     man_t;
  logic                 guard, sticky, round_up;
  logic [MAN_W:0]       man_rnd;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         res;
  logic [3:0]           flg;

  always_comb begin
    a_exp  = bus.A[W-2:MAN_W];
    b_exp  = bus.B[W-2:MAN_W];
    a_man  = bus.A[MAN_W-1:0];
    b_man  = bus.B[MAN_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_nan  = (&a_exp) & (|a_man);
    b_nan  = (&b_exp) & (|b_man);
    a_inf  = (&a_exp) & ~(|a_man);
    b_inf  = (&b_exp) & ~(|b_man);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      cls_in = CLS_NAN;
    else if (a_inf || b_inf)
      cls_in = CLS_INF;
    else if (a_zero || b_zero)
      cls_in = CLS_ZERO;
    else
      cls_in = CLS_NORM;
    exp_in = $signed(EW'(a_exp)) + $signed(EW'(b_exp)) - BIAS;
  end

  // Product of two hidden-bit mantissas lies in [1,4): at most one right shift.
  always_comb begin
    norm_shift = s2_prod_q[PW-1];
    prod_n     = norm_shift ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    man_t      = prod_n[PW-2 -: MAN_W];
    guard      = prod_n[MAN_W];
    sticky     = |prod_n[MAN_W-1:0];
    round_up   = guard & (sticky | man_t[0]);
    man_rnd    = {1'b0, man_t} + (MAN_W+1)'(round_up);
    exp_r      = s2_exp_q + EW'(norm_shift) + EW'(man_rnd[MAN_W]);

    res = '0;
    flg = '0;
    case (s2_cls_q)
      CLS_NAN: begin
        res = QNAN;
        flg = 4'b1000;
      end
      CLS_INF:  res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg = 4'b0101;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
          res = {s2_sign_q, {(W-1){1'b0}}};
          flg = 4'b0011;
        end else begin
          // On rounding carry man_rnd's low bits are already zero.
          res = {s2_sign_q, exp_r[EXP_W-1:0], man_rnd[MAN_W-1:0]};
          flg = {3'b000, guard | sticky};
        end
      end
    endcase
  end

  always_comb begin
    adv  = ~v3_q | bus.out_ready;
    v1_d = adv ? bus.in_valid : v1_q;
    v2_d = adv ? v1_q : v2_q;
    v3_d = adv ? v2_q : v3_q;

    s1_sign_d = s1_sign_q;
    s1_cls_d  = s1_cls_q;
    s1_exp_d  = s1_exp_q;
    s1_ma_d   = s1_ma_q;
    s1_mb_d   = s1_mb_q;
    if (adv && bus.in_valid) begin
      s1_sign_d = bus.A[W-1] ^ bus.B[W-1];
      s1_cls_d  = cls_in;
      s1_exp_d  = exp_in;
      s1_ma_d   = {1'b1, a_man};
      s1_mb_d   = {1'b1, b_man};
    end

    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_exp_d  = s2_exp_q;
    s2_prod_d = s2_prod_q;
    if (adv && v1_q) begin
      s2_sign_d = s1_sign_q;
      s2_cls_d  = s1_cls_q;
      s2_exp_d  = s1_exp_q;
      s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
    end

    out_d   = out_q;
    flags_d = flags_q;
    if (adv && v2_q) begin
      out_d   = res;
      flags_d = flg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= CLS_NORM;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s2_sign_q <= 1'b0;
      s2_cls_q  <= CLS_NORM;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      out_q     <= '0;
      flags_q   <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_sign_q <= s1_sign_d;
      s1_cls_q  <= s1_cls_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= s1_ma_d;
      s1_mb_q   <= s1_mb_d;
      s2_sign_q <= s2_sign_d;
      s2_cls_q  <= s2_cls_d;
      s2_exp_q  <= s2_exp_d;
      s2_prod_q <= s2_prod_d;
      out_q     <= out_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed and streaming checks of fp_mul_pipe in binary32 and binary16.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.W(32)) b32 ();
  fp_mul_pipe_if #(.W(16)) b16 ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  // Reference binary32 product {flags, result} for normal, finite operands.
  function automatic logic [35:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p, q, rem, half;
    int          sh, e;
    logic        nx, s;
    s    = a[31] ^ b[31];
    p    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    sh   = p[47] ? 24 : 23;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127 + (p[47] ? 1 : 0);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'd1 << (sh - 1);
    nx   = (rem != 48'd0);
    if (rem > half || (rem == half && q[0])) q = q + 48'd1;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0011, s, 31'd0};
    return {3'b000, nx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic [7:0]  ex;
    logic [22:0] mn;
    ex = 8'($urandom_range(100, 150));
    mn = 23'($urandom);
    return {1'($urandom), ex, mn};
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    b32.A = a;
    b32.B = b;
    b32.in_valid  = 1'b1;
    b32.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!b32.out_valid) lat = -1;
    r = b32.out;
    f = b32.flags;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    b16.A = a;
    b16.B = b;
    b16.in_valid  = 1'b1;
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    lat = 1;
    while (!b16.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!b16.out_valid) lat = -1;
    r = b16.out;
    f = b16.flags;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.out !== 32'd0 || b32.flags !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%b out=%h flags=%b want 0/0/0",
               b32.out_valid, b32.out, b32.flags);
    end
    checks++;
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", b32.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    run32(32'h3FC00000, 32'h40000000, r, f, lat);
    checks++;
    if (r !== 32'h40400000 || f !== 4'b0000) begin
      failures++;
      $display("FAIL basic_mul got=%h/%b want=40400000/0000", r, f);
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=3", lat);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va [10] = '{32'h3F800800, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000,
                             32'hFF800000, 32'h80000000, 32'h7FC12345, 32'h00000001, 32'h00800000};
    logic [31:0] vb [10] = '{32'h3F800800, 32'h3F800001, 32'h40000000, 32'h3F000000, 32'h00000000,
                             32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vr [10] = '{32'h3F801000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                             32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000, 32'h00800000};
    logic [3:0]  vf [10] = '{4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b1000,
                             4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      run32(va[i], vb[i], r, f, lat);
      checks++;
      if (r !== vr[i] || f !== vf[i] || lat !== 3) begin
        failures++;
        $display("FAIL vector_%0d %h*%h got=%h/%b lat=%0d want=%h/%b lat=3",
                 i, va[i], vb[i], r, f, lat, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] q[$];
    logic [35:0] e;
    logic [31:0] a, b;
    int          got = 0, gaps = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (i < 100) begin
        a = rnd_norm();
        b = rnd_norm();
        b32.A = a;
        b32.B = b;
        b32.in_valid = 1'b1;
      end else begin
        b32.in_valid = 1'b0;
      end
      b32.out_ready = 1'b1;
      #1;
      if (i >= 3 && i < 103 && !b32.out_valid) gaps++;
      if (b32.out_valid && b32.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 36'hx;
        got++;
        checks++;
        if ({b32.flags, b32.out} !== e) begin
          failures++;
          $display("FAIL stream_result_%0d got=%h/%b want=%h/%b",
                   got, b32.out, b32.flags, e[31:0], e[35:32]);
        end
      end
      if (b32.in_valid && b32.in_ready) q.push_back(ref32(a, b));
    end
    checks++;
    if (gaps !== 0 || got !== 100) begin
      failures++;
      $display("FAIL stream_throughput got gaps=%0d results=%0d want 0/100", gaps, got);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pa [5] = '{32'h3FC00000, 32'h40400000, 32'hC0000000, 32'h3F800001, 32'h41200000};
    logic [31:0] pb [5] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h41200000};
    logic [35:0] q[$];
    logic [35:0] e;
    logic [31:0] held;
    int          acc = 0, got = 0, n = 0;
    b32.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b32.in_valid = 1'b1;
      b32.A = pa[acc];
      b32.B = pb[acc];
      #1;
      if (i == 4) held = b32.out;
      if (b32.in_valid && b32.in_ready) begin
        q.push_back(ref32(pa[acc], pb[acc]));
        acc++;
      end
    end
    checks++;
    if (acc !== 3 || b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_capacity got accepted=%0d in_ready=%b out_valid=%b want 3/0/1",
               acc, b32.in_ready, b32.out_valid);
    end
    checks++;
    if (b32.out !== held || held !== 32'h40400000) begin
      failures++;
      $display("FAIL bp_stall_stable got=%h earlier=%h want 40400000", b32.out, held);
    end
    b32.out_ready = 1'b1;
    while ((got < 5 || acc < 5) && n < 30) begin
      if (n > 0) @(negedge clk);
      n++;
      b32.in_valid = (acc < 5);
      if (acc < 5) begin
        b32.A = pa[acc];
        b32.B = pb[acc];
      end
      #1;
      if (b32.out_valid && b32.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 36'hx;
        got++;
        checks++;
        if ({b32.flags, b32.out} !== e) begin
          failures++;
          $display("FAIL bp_result_%0d got=%h/%b want=%h/%b",
                   got, b32.out, b32.flags, e[31:0], e[35:32]);
        end
      end
      if (b32.in_valid && b32.in_ready) begin
        q.push_back(ref32(pa[acc], pb[acc]));
        acc++;
      end
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (got !== 5 || b32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got results=%0d out_valid=%b want 5/0", got, b32.out_valid);
    end
  endtask

  task automatic test_random_ready;
    logic [35:0] q[$];
    logic [35:0] e;
    logic [31:0] a, b;
    logic [36:0] prev;
    logic        hold = 1'b0;
    int          sent = 0, got = 0, cyc = 0;
    while (got < 1000 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if ({b32.out_valid, b32.flags, b32.out} !== prev) begin
          failures++;
          $display("FAIL rr_hold_stable got=%h want=%h", {b32.out_valid, b32.flags, b32.out}, prev);
        end
      end
      a = rnd_norm();
      b = rnd_norm();
      b32.A = a;
      b32.B = b;
      b32.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b32.out_ready = 1'($urandom);
      #1;
      hold = b32.out_valid && !b32.out_ready;
      prev = {b32.out_valid, b32.flags, b32.out};
      if (b32.out_valid && b32.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 36'hx;
        got++;
        checks++;
        if ({b32.flags, b32.out} !== e) begin
          failures++;
          $display("FAIL rr_result_%0d got=%h/%b want=%h/%b",
                   got, b32.out, b32.flags, e[31:0], e[35:32]);
        end
      end
      if (b32.in_valid && b32.in_ready) begin
        q.push_back(ref32(a, b));
        sent++;
      end
    end
    @(negedge clk);
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    checks++;
    if (got !== 1000 || q.size() !== 0) begin
      failures++;
      $display("FAIL rr_count got results=%0d pending=%0d want 1000/0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream;
    int stale = 0;
    b32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b32.in_valid = 1'b1;
      b32.A = 32'h3FC00000;
      b32.B = 32'h40000000;
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    #1;
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out !== 32'h40400000) begin
      failures++;
      $display("FAIL rst_precondition got valid=%b out=%h want 1/40400000", b32.out_valid, b32.out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.out !== 32'd0 || b32.flags !== 4'd0) begin
      failures++;
      $display("FAIL rst_immediate got valid=%b out=%h flags=%b want 0/0/0",
               b32.out_valid, b32.out, b32.flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    #1;
    checks++;
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready got=%b want=1", b32.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b32.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL rst_stale_result got=%0d valid cycles want=0", stale);
    end
  endtask

  task automatic test_half;
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    run16(16'h3C00, 16'h4000, r, f, lat);
    checks++;
    if (r !== 16'h4000 || f !== 4'b0000 || lat !== 3) begin
      failures++;
      $display("FAIL half_one_times_two got=%h/%b lat=%0d want=4000/0000 lat=3", r, f, lat);
    end
    run16(16'h7BFF, 16'h4000, r, f, lat);
    checks++;
    if (r !== 16'h7C00 || f !== 4'b0101) begin
      failures++;
      $display("FAIL half_overflow got=%h/%b want=7c00/0101", r, f);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.A = '0; b32.B = '0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.A = '0; b16.B = '0;
    repeat (3) @(posedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic;
    test_vectors;
    test_back_to_back;
    test_backpressure;
    test_random_ready;
    test_reset_midstream;
    test_half;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
